// File: rtl/rv32i_types.sv
// Shared RV32I encodings and the memory-stage state type.
// Imported by the memory stage and its load formatter.
package rv32i_types;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    lb  = 3'b000,
    lh  = 3'b001,
    lw  = 3'b010,
    lbu = 3'b100,
    lhu = 3'b101
  } load_funct3_t;

  typedef enum logic [2:0] {
    sb = 3'b000,
    sh = 3'b001,
    sw = 3'b010
  } store_funct3_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    HOLD = 2'd2
  } mem_state_t;

endpackage

// File: rtl/mem_load_align.sv
// Load formatter: picks the byte/half lane and extends it.
// Undefined width codes pass the word through unchanged.
module mem_load_align
  import rv32i_types::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rdata[{off, 3'b000} +: 8];
  assign half_sel = off[1] ? rdata[31:16] : rdata[15:0];

  // Extend the selected lane according to the load width.
  always_comb begin
    result = rdata;
    case (funct3)
      lb:      result = {{24{byte_sel[7]}}, byte_sel};
      lh:      result = {{16{half_sel[15]}}, half_sel};
      lbu:     result = {24'd0, byte_sel};
      lhu:     result = {16'd0, half_sel};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: one request per live load/store,
// held until dmem_resp, with a hold slot for frozen downstream.
module mem_stage
  import rv32i_types::*;
#(
  parameter int XLEN = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_store_data,
  input  logic        advance,
  output logic [31:0] dmem_address,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [3:0]  dmem_mbe,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_resp,
  output logic [31:0] load_data,
  output logic        mem_stall,
  output logic        misaligned
);

  mem_state_t  state;
  logic [31:0] hold_data;
  logic [31:0] aligned;
  logic [1:0]  w;
  logic [1:0]  off;
  logic        is_mem;
  logic        is_rd;
  logic        is_wr;
  logic        mis_c;
  logic        access;
  logic        req;
  logic [31:0] fmt;

  assign w      = ex_funct3[1:0];
  assign off    = ex_addr[1:0];
  assign is_mem = ex_valid & (ex_mem_read | ex_mem_write);
  // Read wins when both flags are set.
  assign is_rd  = ex_mem_read;
  assign is_wr  = ex_mem_write & ~ex_mem_read;

  // Byte accesses are always aligned; halves need even, words need 4.
  always_comb begin
    mis_c = 1'b0;
    unique case (1'b1)
      (w == 2'b00): mis_c = 1'b0;
      (w == 2'b01): mis_c = off[0];
      default:      mis_c = (off != 2'b00);
    endcase
  end

  assign misaligned = rst & is_mem & mis_c & (state == IDLE);
  assign access     = is_mem & ~mis_c;
  assign req = rst & ((state == IDLE & access) | (state == BUSY));

  mem_load_align u_align (
    .rdata  (dmem_rdata),
    .off    (off),
    .funct3 (ex_funct3),
    .result (aligned)
  );

  assign fmt = is_rd ? aligned : 32'd0;

  assign dmem_address = {ex_addr[31:2], 2'b00};
  assign dmem_read    = req & is_rd;
  assign dmem_write   = req & is_wr;
  assign mem_stall    = req & ~dmem_resp;

  // Byte enables and lane-replicated store data.
  always_comb begin
    dmem_mbe   = 4'b0000;
    dmem_wdata = ex_store_data;
    if (req) begin
      dmem_mbe = 4'b1111;
      if (is_wr) begin
        unique case (1'b1)
          (w == 2'b00): begin
            dmem_mbe   = 4'b0001 << off;
            dmem_wdata = {4{ex_store_data[7:0]}};
          end
          (w == 2'b01): begin
            dmem_mbe   = 4'b0011 << off;
            dmem_wdata = {2{ex_store_data[15:0]}};
          end
          default: begin
            dmem_mbe   = 4'b1111;
            dmem_wdata = ex_store_data;
          end
        endcase
      end
    end
  end

  // Response cycle forwards formatted data; HOLD replays it.
  always_comb begin
    load_data = 32'd0;
    if (rst) begin
      if (state == HOLD)
        load_data = hold_data;
      else if (req & dmem_resp)
        load_data = fmt;
    end
  end

  // Request FSM and hold register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      hold_data <= 32'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (access & ~dmem_resp) begin
            state <= BUSY;
          end else if (access & ~advance) begin
            state     <= HOLD;
            hold_data <= fmt;
          end
        end
        BUSY: begin
          if (dmem_resp & advance) begin
            state <= IDLE;
          end else if (dmem_resp) begin
            state     <= HOLD;
            hold_data <= fmt;
          end
        end
        HOLD: begin
          if (advance) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Conflicting load/store flags are a decode bug upstream.
  always_ff @(posedge clk) begin
    assert (!(rst && ex_valid && ex_mem_read && ex_mem_write))
      else $error("mem_stage: read and write both set");
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage.
// Inputs change on negedge; outputs sampled 1 time unit later.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_addr;
  logic [31:0] ex_store_data;
  logic        advance;
  logic [31:0] dmem_address;
  logic        dmem_read;
  logic        dmem_write;
  logic [3:0]  dmem_mbe;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;
  logic [31:0] load_data;
  logic        mem_stall;
  logic        misaligned;

  int checks = 0;
  int failures = 0;
  int writes = 0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk           (clk),
    .rst           (rst),
    .ex_valid      (ex_valid),
    .ex_mem_read   (ex_mem_read),
    .ex_mem_write  (ex_mem_write),
    .ex_funct3     (ex_funct3),
    .ex_addr       (ex_addr),
    .ex_store_data (ex_store_data),
    .advance       (advance),
    .dmem_address  (dmem_address),
    .dmem_read     (dmem_read),
    .dmem_write    (dmem_write),
    .dmem_mbe      (dmem_mbe),
    .dmem_wdata    (dmem_wdata),
    .dmem_rdata    (dmem_rdata),
    .dmem_resp     (dmem_resp),
    .load_data     (load_data),
    .mem_stall     (mem_stall),
    .misaligned    (misaligned)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply one cycle's inputs at negedge, then settle.
  task automatic drive(input logic v, input logic rd, input logic wr,
                       input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] sd, input logic rsp,
                       input logic [31:0] rdat, input logic adv);
    @(negedge clk);
    ex_valid = v; ex_mem_read = rd; ex_mem_write = wr;
    ex_funct3 = f3; ex_addr = a; ex_store_data = sd;
    dmem_resp = rsp; dmem_rdata = rdat; advance = adv;
    #1;
    if (dmem_write) writes++;
  endtask

  initial begin
    rst = 1'b0;
    drive(0, 0, 0, 3'b010, 32'h0, 32'h0, 0, 32'h0, 0);
    drive(0, 0, 0, 3'b010, 32'h0, 32'h0, 0, 32'h0, 0);
    chk("rst_state", 32'(dut.state), 32'd0);
    chk("rst_read", 32'(dmem_read), 0);
    chk("rst_stall", 32'(mem_stall), 0);
    chk("rst_mbe", 32'(dmem_mbe), 0);
    chk("rst_ld", load_data, 0);
    @(negedge clk);
    rst = 1'b1;

    // LW 0x100, response on third request cycle
    drive(1, 1, 0, 3'b010, 32'h100, 32'h0, 0, 32'h0, 0);
    chk("lw_c1_rd", 32'(dmem_read), 1);
    chk("lw_c1_addr", dmem_address, 32'h100);
    chk("lw_c1_stall", 32'(mem_stall), 1);
    chk("lw_c1_mbe", 32'(dmem_mbe), 32'hF);
    drive(1, 1, 0, 3'b010, 32'h100, 32'h0, 0, 32'h0, 0);
    chk("lw_c2_state", 32'(dut.state), 32'd1);
    chk("lw_c2_rd", 32'(dmem_read), 1);
    chk("lw_c2_stall", 32'(mem_stall), 1);
    drive(1, 1, 0, 3'b010, 32'h100, 32'h0, 1, 32'hDEADBEEF, 1);
    chk("lw_c3_rd", 32'(dmem_read), 1);
    chk("lw_c3_stall", 32'(mem_stall), 0);
    chk("lw_c3_ld", load_data, 32'hDEADBEEF);
    drive(0, 0, 0, 3'b010, 32'h0, 32'h0, 0, 32'h0, 1);
    chk("lw_after_state", 32'(dut.state), 32'd0);
    chk("lw_after_rd", 32'(dmem_read), 0);
    chk("lw_after_ld", load_data, 0);

    // Zero-wait sub-word loads
    drive(1, 1, 0, 3'b000, 32'h103, 32'h0, 1, 32'h80FF0000, 1);
    chk("lb_ld", load_data, 32'hFFFFFF80);
    chk("lb_stall", 32'(mem_stall), 0);
    drive(1, 1, 0, 3'b100, 32'h103, 32'h0, 1, 32'h80FF0000, 1);
    chk("lbu_ld", load_data, 32'h00000080);
    drive(1, 1, 0, 3'b001, 32'h102, 32'h0, 1, 32'h80FF0000, 1);
    chk("lh_ld", load_data, 32'hFFFF80FF);
    chk("lh_mis", 32'(misaligned), 0);
    drive(1, 1, 0, 3'b101, 32'h100, 32'h0, 1, 32'h80FF8001, 1);
    chk("lhu_ld", load_data, 32'h00008001);

    // Sub-word stores
    drive(1, 0, 1, 3'b000, 32'h201, 32'h123456AB, 1, 32'h0, 1);
    chk("sb_wr", 32'(dmem_write), 1);
    chk("sb_rd", 32'(dmem_read), 0);
    chk("sb_mbe", 32'(dmem_mbe), 32'b0010);
    chk("sb_wdata", dmem_wdata, 32'hABABABAB);
    chk("sb_addr", dmem_address, 32'h200);
    drive(1, 0, 1, 3'b001, 32'h202, 32'h123456AB, 1, 32'h0, 1);
    chk("sh_mbe", 32'(dmem_mbe), 32'b1100);
    chk("sh_wdata", dmem_wdata, 32'h56AB56AB);

    // Store completes while downstream frozen
    writes = 0;
    drive(1, 0, 1, 3'b010, 32'h300, 32'hCAFEF00D, 1, 32'h0, 0);
    chk("sw_wr", 32'(dmem_write), 1);
    chk("sw_wdata", dmem_wdata, 32'hCAFEF00D);
    chk("sw_stall", 32'(mem_stall), 0);
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 1, 3'b010, 32'h300, 32'hCAFEF00D, 0, 32'h0, 0);
      chk("sw_hold_state", 32'(dut.state), 32'd2);
      chk("sw_hold_stall", 32'(mem_stall), 0);
    end
    drive(1, 0, 1, 3'b010, 32'h300, 32'hCAFEF00D, 0, 32'h0, 1);
    drive(0, 0, 0, 3'b010, 32'h0, 32'h0, 0, 32'h0, 0);
    chk("sw_idle", 32'(dut.state), 32'd0);
    chk("sw_once", 32'(writes), 1);

    // Load completes while frozen; hold slot replays it
    drive(1, 1, 0, 3'b010, 32'h400, 32'h0, 1, 32'h11223344, 0);
    chk("hl_ld0", load_data, 32'h11223344);
    drive(1, 1, 0, 3'b010, 32'h400, 32'h0, 0, 32'h0, 0);
    chk("hl_state", 32'(dut.state), 32'd2);
    chk("hl_ld1", load_data, 32'h11223344);
    chk("hl_rd", 32'(dmem_read), 0);
    drive(1, 1, 0, 3'b010, 32'h400, 32'h0, 0, 32'h0, 1);
    drive(0, 0, 0, 3'b010, 32'h0, 32'h0, 0, 32'h0, 0);
    chk("hl_idle", 32'(dut.state), 32'd0);

    // Misaligned accesses
    drive(1, 1, 0, 3'b010, 32'h102, 32'h0, 0, 32'hFFFFFFFF, 0);
    chk("mis_w", 32'(misaligned), 1);
    chk("mis_w_rd", 32'(dmem_read), 0);
    chk("mis_w_stall", 32'(mem_stall), 0);
    chk("mis_w_ld", load_data, 0);
    drive(1, 0, 1, 3'b001, 32'h101, 32'h0, 0, 32'h0, 0);
    chk("mis_h", 32'(misaligned), 1);
    chk("mis_h_wr", 32'(dmem_write), 0);
    drive(0, 0, 0, 3'b010, 32'h0, 32'h0, 0, 32'h0, 0);
    chk("mis_state", 32'(dut.state), 32'd0);

    // Spurious response while idle
    drive(0, 0, 0, 3'b010, 32'h0, 32'h0, 1, 32'h55555555, 0);
    chk("spur_ld", load_data, 0);
    drive(0, 0, 0, 3'b010, 32'h0, 32'h0, 0, 32'h0, 0);
    chk("spur_state", 32'(dut.state), 32'd0);

    // Reset mid-BUSY, late response afterwards
    drive(1, 1, 0, 3'b010, 32'h500, 32'h0, 0, 32'h0, 0);
    drive(1, 1, 0, 3'b010, 32'h500, 32'h0, 0, 32'h0, 0);
    chk("rb_busy", 32'(dut.state), 32'd1);
    chk("rb_rd", 32'(dmem_read), 1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rb_rd_rst", 32'(dmem_read), 0);
    chk("rb_stall_rst", 32'(mem_stall), 0);
    @(negedge clk);
    rst = 1'b1;
    ex_valid = 1'b0;
    dmem_resp = 1'b1;
    dmem_rdata = 32'hAAAAAAAA;
    #1;
    chk("rb_state", 32'(dut.state), 32'd0);
    chk("rb_rd2", 32'(dmem_read), 0);
    chk("rb_ld", load_data, 0);
    chk("rb_stall2", 32'(mem_stall), 0);
    drive(0, 0, 0, 3'b010, 32'h0, 32'h0, 0, 32'h0, 0);
    chk("rb_state2", 32'(dut.state), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage between the EX/MEM and MEM/WB pipeline registers.
- Issues one data-memory read or write per valid instruction and holds the request until `dmem_resp`.
- Generates byte enables and store-data lane replication; extracts, aligns and sign/zero-extends load data for the MEM/WB register.
- Stalls the pipeline while an access is outstanding and keeps a completed result stable while downstream is frozen.

Parameters:
- XLEN, 32, datapath/address width; 32 is the only supported value.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- ex_valid  in  1  EX/MEM holds a live instruction
- ex_mem_read  in  1  instruction is a load
- ex_mem_write  in  1  instruction is a store
- ex_funct3  in  3  load/store width code (RV32I encoding)
- ex_addr  in  32  effective address (alu_out)
- ex_store_data  in  32  rs2 value for stores
- advance  in  1  MEM/WB register enable this cycle (global pipeline advance)
- dmem_address  out  32  word-aligned address {ex_addr[31:2],2'b00}
- dmem_read  out  1  read request
- dmem_write  out  1  write request
- dmem_mbe  out  4  byte enables
- dmem_wdata  out  32  lane-replicated store data
- dmem_rdata  in  32  read data, valid with dmem_resp
- dmem_resp  in  1  access complete
- load_data  out  32  aligned, extended load result to MEM/WB dmem_rdata_in
- mem_stall  out  1  access outstanding; freezes all pipeline registers
- misaligned  out  1  current access misaligned and suppressed

Behaviour:
- Clock and reset: one clock, `clk`. Reset `rst` is synchronous and active-low.
- While rst=0: state=IDLE, hold_data=0. Outputs dmem_read, dmem_write, mem_stall, misaligned, dmem_mbe and load_data are all 0.
- access = ex_valid & (ex_mem_read | ex_mem_write) & ~misaligned.
- Misaligned detection:
  - halfword (funct3[1:0]=01) with addr[0]=1 is misaligned;
  - word (funct3[1:0]=10, or any undefined code) with addr[1:0]!=0 is misaligned.
  - A misaligned access issues no request, asserts misaligned, drives load_data=0 and never stalls.
- Store encoding:
  - SB: mbe=4'b0001<<addr[1:0], wdata={4{rs2[7:0]}}.
  - SH: mbe=4'b0011<<addr[1:0], wdata={2{rs2[15:0]}}.
  - SW: mbe=4'b1111, wdata=rs2.
  - Loads drive mbe=4'b1111.
- Load decoding: byte/half selected by addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- FSM state IDLE:
  - dmem_read/dmem_write = access & ex_mem_read/ex_mem_write, driven combinationally.
  - mem_stall = access & ~dmem_resp.
  - access & ~dmem_resp -> BUSY.
  - access & dmem_resp & ~advance -> HOLD, capture formatted data into hold_data.
  - otherwise stay IDLE.
- FSM state BUSY:
  - request held with identical address, mbe and wdata; mem_stall = ~dmem_resp.
  - dmem_resp & advance -> IDLE.
  - dmem_resp & ~advance -> HOLD, capture hold_data.
- FSM state HOLD:
  - no request; mem_stall=0; load_data=hold_data.
  - advance -> IDLE. No re-issue, so a store is never written twice.
- Response-cycle data path: load_data is formatted from dmem_rdata combinationally, so MEM/WB captures it in the response cycle (zero added latency). In IDLE with no access, load_data=0.
- Zero-wait memory: dmem_resp in the same cycle as the request gives no stall cycle.
- Spurious/late dmem_resp (IDLE with no access, or after reset mid-BUSY) is ignored.
- A reset asserted mid-BUSY abandons the request in the next cycle.
- ex_mem_read and ex_mem_write both high: treated as a read; assertion error in simulation.

Decomposition:
- rv32i_types package:
  - load_funct3_t / store_funct3_t enums (lb, lh, lw, lbu, lhu; sb, sh, sw) are reused;
  - add mem_state_t {IDLE, BUSY, HOLD}.
- Sub-module mem_load_align: combinational (rdata, addr[1:0], funct3) -> extended 32-bit result.

Test Plan:
- LW addr 0x100, resp after 3 cycles, advance follows stall -> dmem_read high 3 cycles at 0x100, mem_stall=1 for 2 cycles then 0, load_data=dmem_rdata.
- LB addr 0x103, dmem_rdata=0x80FF_0000 -> load_data=0xFFFF_FF80; LBU same -> 0x0000_0080; LH addr 0x102 -> 0xFFFF_80FF.
- SB addr 0x201, rs2=0x1234_56AB -> mbe=4'b0010, wdata=0xABAB_ABAB; SH addr 0x202 -> mbe=4'b1100, wdata=0x56AB_56AB.
- Store resp while advance=0 for 4 cycles -> exactly one dmem_write cycle; state HOLD; no second write; IDLE after advance.
- LW addr 0x102 -> misaligned=1, no dmem_read, mem_stall=0, load_data=0.
- rst=0 mid-BUSY, then dmem_resp one cycle later -> requests drop the cycle after reset, resp ignored, state IDLE, outputs 0.
